cmd_phy_engine: RTL and testbench

//  Parametrised SD CMD-line physical engine, successor to the fixed 48-bit command PHY.
//  - Serialises 48-bit commands with computed CRC7.
//  - Receives no-response, 48-bit short or 136-bit long (R2) responses; timeout programmable.
//  - Sits between the CMD transaction layer (REQ/ACK handshake) and the SD card CMD pin.

---
 rtl/cmd_phy_engine_if.sv | 24 ++
 rtl/cmd_phy_engine.sv | 169 ++++++++++++++++
 tb/tb_cmd_phy_engine.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_phy_engine_if.sv
// Handshake/bus bundle between the CMD transaction layer (master) and cmd_phy_engine (slave).
interface cmd_phy_engine_if;
  logic         new_cmd;
  logic [37:0]  cmd_index_arg;
  logic [1:0]   resp_type;
  logic         REQ_in;
  logic         ACK_in;
  logic         ACK_out;
  logic         REQ_out;
  logic [127:0] cmd_response;
  logic         timeout_error;
  logic         crc_error;
  logic         physical_inactive;

  modport master (
    output new_cmd, cmd_index_arg, resp_type, REQ_in, ACK_in,
    input  ACK_out, REQ_out, cmd_response, timeout_error, crc_error, physical_inactive
  );

  modport slave (
    input  new_cmd, cmd_index_arg, resp_type, REQ_in, ACK_in,
    output ACK_out, REQ_out, cmd_response, timeout_error, crc_error, physical_inactive
  );
endinterface

// File: rtl/cmd_phy_engine.sv
// SD CMD-line PHY: serialises 48-bit commands with CRC7, receives none/short/long responses.
// Optional receive CRC7 checker enabled by defining CMD_CRC_CHECK_EN.
module cmd_phy_engine #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_CNT_W       = 8,
  parameter int SHORT_BITS     = 48,
  parameter int LONG_BITS      = 136
) (
  input  logic              CLK_SD_card,
  input  logic              reset,
  cmd_phy_engine_if.slave   bus,
  input  logic              cmd_from_sd,
  output logic              cmd_to_sd,
  output logic              cmd_to_sd_oe
);

  localparam int RX_CNT_W = $clog2(LONG_BITS + 1);

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    SETUP     = 6'b000010,
    SEND      = 6'b000100,
    WAIT_RESP = 6'b001000,
    RECV      = 6'b010000,
    RETURN    = 6'b100000
  } state_t;

  state_t                state;
  logic [46:0]           tx_shift;
  logic [5:0]            tx_cnt;
  logic [TO_CNT_W-1:0]   to_cnt;
  logic [126:0]          rx_shift;
  logic [RX_CNT_W-1:0]   rx_cnt;
  logic [1:0]            rtype;

  logic [47:0]           tx_frame_c;
  logic [127:0]          rx_next;
  logic                  rx_last;
  logic [127:0]          resp_c;
  logic                  crc_bad_c;

  // Serial CRC7 (x^7+x^3+1, init 0); leading zero bits leave it unchanged,
  // so shorter messages are zero-extended into the 120-bit window.
  function automatic logic [6:0] crc7(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 120; i++) begin
      fb = d[119-i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  always_comb begin
    tx_frame_c = {2'b01, bus.cmd_index_arg,
                  crc7({80'b0, 2'b01, bus.cmd_index_arg}), 1'b1};
    rx_next    = {rx_shift, cmd_from_sd};
    rx_last    = (rtype == 2'b10) ? (rx_cnt == RX_CNT_W'(LONG_BITS - 1))
                                  : (rx_cnt == RX_CNT_W'(SHORT_BITS - 1));
    resp_c     = (rtype == 2'b10) ? rx_next : {90'b0, rx_next[45:8]};
  end

`ifdef CMD_CRC_CHECK_EN
  always_comb begin
    crc_bad_c = 1'b0;
    if (rtype == 2'b10)
      crc_bad_c = (crc7(rx_next[127:8]) != rx_next[7:1]);
    else if (rtype != 2'b11)
      crc_bad_c = (crc7({80'b0, rx_next[47:8]}) != rx_next[7:1]);
  end
`else
  always_comb crc_bad_c = 1'b0;
`endif

  always_ff @(posedge CLK_SD_card) begin
    if (reset) begin
      state                 <= IDLE;
      tx_shift              <= '0;
      tx_cnt                <= '0;
      to_cnt                <= '0;
      rx_shift              <= '0;
      rx_cnt                <= '0;
      rtype                 <= '0;
      cmd_to_sd             <= 1'b1;
      cmd_to_sd_oe          <= 1'b0;
      bus.ACK_out           <= 1'b0;
      bus.REQ_out           <= 1'b0;
      bus.cmd_response      <= '0;
      bus.timeout_error     <= 1'b0;
      bus.crc_error         <= 1'b0;
      bus.physical_inactive <= 1'b1;
    end else begin
      bus.ACK_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.new_cmd) begin
            state                 <= SETUP;
            bus.physical_inactive <= 1'b0;
          end
        end
        SETUP: begin
          if (bus.REQ_in) begin
            tx_shift     <= tx_frame_c[46:0];
            rtype        <= bus.resp_type;
            cmd_to_sd    <= tx_frame_c[47];
            cmd_to_sd_oe <= 1'b1;
            tx_cnt       <= '0;
            bus.ACK_out  <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (tx_cnt == 6'd47) begin
            cmd_to_sd    <= 1'b1;
            cmd_to_sd_oe <= 1'b0;
            to_cnt       <= '0;
            if (rtype == 2'b00) begin
              bus.REQ_out <= 1'b1;
              state       <= RETURN;
            end else begin
              state <= WAIT_RESP;
            end
          end else begin
            cmd_to_sd <= tx_shift[46];
            tx_shift  <= {tx_shift[45:0], 1'b1};
            tx_cnt    <= tx_cnt + 6'd1;
          end
        end
        WAIT_RESP: begin
          // Start bit is tested before the timeout so it wins on the final cycle.
          if (!cmd_from_sd) begin
            rx_shift <= '0;
            rx_cnt   <= RX_CNT_W'(1);
            state    <= RECV;
          end else if (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.timeout_error <= 1'b1;
            bus.REQ_out       <= 1'b1;
            state             <= RETURN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RECV: begin
          rx_shift <= rx_next[126:0];
          rx_cnt   <= rx_cnt + 1'b1;
          if (rx_last) begin
            bus.cmd_response <= resp_c;
            bus.crc_error    <= crc_bad_c;
            bus.REQ_out      <= 1'b1;
            state            <= RETURN;
          end
        end
        RETURN: begin
          if (bus.ACK_in) begin
            bus.REQ_out           <= 1'b0;
            bus.timeout_error     <= 1'b0;
            bus.crc_error         <= 1'b0;
            bus.cmd_response      <= '0;
            bus.physical_inactive <= 1'b1;
            state                 <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_phy_engine.sv
// Self-checking bench for cmd_phy_engine: CRC7 model by polynomial division, card emulation, per-cycle monitor.
module tb_cmd_phy_engine;

`ifdef CMD_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic CLK_SD_card = 1'b0;
  logic reset;
  logic cmd_from_sd;
  logic cmd_to_sd;
  logic cmd_to_sd_oe;

  cmd_phy_engine_if bus ();

  cmd_phy_engine #(
    .TIMEOUT_CYCLES (64),
    .TO_CNT_W       (8),
    .SHORT_BITS     (48),
    .LONG_BITS      (136)
  ) dut (
    .CLK_SD_card  (CLK_SD_card),
    .reset        (reset),
    .bus          (bus),
    .cmd_from_sd  (cmd_from_sd),
    .cmd_to_sd    (cmd_to_sd),
    .cmd_to_sd_oe (cmd_to_sd_oe)
  );

  always #5 CLK_SD_card = ~CLK_SD_card;

  int          tests = 0;
  int          fails = 0;
  logic [47:0]  exp_tx_frame;
  logic [127:0] exp_resp;
  logic         exp_crc;
  logic         exp_to;
  bit           chk_tx;

  function automatic void chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc_div(input logic [119:0] msg, input int unsigned nbits);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int unsigned i = nbits + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc_div({80'b0, 2'b01, idx, arg}, 40), 1'b1};
  endfunction

  function automatic logic short_crc_bad(input logic [47:0] f, input logic [1:0] rt);
    return CRC_ON && (rt != 2'b11) && (crc_div({80'b0, f[47:8]}, 40) != f[7:1]);
  endfunction

  function automatic logic long_crc_bad(input logic [135:0] f);
    return CRC_ON && (crc_div(f[127:8], 120) != f[7:1]);
  endfunction

  // Compare process: checks transmit stream and handshake/response outputs every cycle.
  initial begin
    int unsigned tx_idx;
    logic oe_prev;
    logic ack_prev;
    tx_idx = 0; oe_prev = 1'b0; ack_prev = 1'b0;
    forever begin
      @(negedge CLK_SD_card);
      if (reset !== 1'b0) begin
        oe_prev = 1'b0; ack_prev = 1'b0;
      end else begin
        if (bus.ACK_out === 1'b1) begin
          chk("ack_one_cycle", ack_prev, 0);
          chk("ack_with_oe", cmd_to_sd_oe, 1);
          tx_idx = 0;
        end
        if (chk_tx) begin
          if (cmd_to_sd_oe === 1'b1) begin
            if (tx_idx < 48) chk("tx_bit", cmd_to_sd, exp_tx_frame[47 - tx_idx]);
            tx_idx++;
          end else begin
            chk("line_idle", cmd_to_sd, 1);
            if (oe_prev) chk("oe_cycles", tx_idx, 48);
          end
        end
        if (bus.REQ_out === 1'b1) begin
          chk("resp", bus.cmd_response, exp_resp);
          chk("timeout_error", bus.timeout_error, exp_to);
          chk("crc_error", bus.crc_error, exp_crc);
          chk("active_in_return", bus.physical_inactive, 0);
        end
        if (bus.physical_inactive === 1'b1) begin
          chk("idle_req", bus.REQ_out, 0);
          chk("idle_oe", cmd_to_sd_oe, 0);
          chk("idle_errs", {bus.timeout_error, bus.crc_error}, 0);
          chk("idle_resp", bus.cmd_response, 0);
        end
        oe_prev  = cmd_to_sd_oe;
        ack_prev = bus.ACK_out;
      end
    end
  end

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic [47:0] tx_exp, input logic [135:0] reply, input int unsigned rlen,
                         input int delay, input logic [127:0] e_resp, input logic e_crc,
                         input logic e_to, input int e_wait, input bit abuse);
    int unsigned n;
    exp_tx_frame = tx_exp; exp_resp = e_resp; exp_crc = e_crc; exp_to = e_to;
    @(negedge CLK_SD_card);
    bus.cmd_index_arg = {idx, arg};
    bus.resp_type     = rt;
    bus.new_cmd       = 1'b1;
    @(negedge CLK_SD_card);
    bus.new_cmd = 1'b0;
    bus.REQ_in  = 1'b1;
    n = 0;
    do begin @(negedge CLK_SD_card); n++; end while (bus.ACK_out !== 1'b1 && n < 20);
    chk("ack_out", bus.ACK_out, 1);
    // Stray controls while not in IDLE/SETUP/RETURN must have no effect.
    if (abuse) begin bus.new_cmd = 1'b1; bus.ACK_in = 1'b1; end
    else bus.REQ_in = 1'b0;
    n = 0;
    while (cmd_to_sd_oe === 1'b1 && n < 100) begin @(negedge CLK_SD_card); n++; end
    chk("oe_drop", cmd_to_sd_oe, 0);
    bus.new_cmd = 1'b0; bus.ACK_in = 1'b0; bus.REQ_in = 1'b0;
    if (delay >= 0) begin
      repeat (delay) @(negedge CLK_SD_card);
      for (int unsigned i = 0; i < rlen; i++) begin
        cmd_from_sd = reply[rlen - 1 - i];
        @(negedge CLK_SD_card);
      end
      cmd_from_sd = 1'b1;
    end
    n = 0;
    while (bus.REQ_out !== 1'b1 && n < 300) begin @(negedge CLK_SD_card); n++; end
    if (e_wait >= 0) chk("wait_cycles", n, e_wait);
    chk("req_out", bus.REQ_out, 1);
    repeat (3) @(negedge CLK_SD_card);
    chk("req_held", bus.REQ_out, 1);
    bus.ACK_in = 1'b1;
    @(negedge CLK_SD_card);
    bus.ACK_in = 1'b0;
    chk("idle_after_ack", bus.physical_inactive, 1);
    chk("req_dropped", bus.REQ_out, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0]  r7_good, r7_bad, r3, f17;
    logic [119:0] cid;
    logic [135:0] long_good, long_bad;
    int unsigned  n;

    r7_good = 48'h08_0000_01AA_13;
    r7_bad  = 48'h08_0000_01AA_15;
    r3      = 48'h3F_00FF_8000_FF;
    f17     = 48'h51_0000_0000_55;
    cid     = 120'h03_5344_5344_3136_4780_1234_5678_0123;
    long_good = {8'h3F, cid, crc_div(cid, 120), 1'b1};
    long_bad  = long_good ^ 136'h2;

    chk_tx = 1'b1;
    reset = 1'b1; cmd_from_sd = 1'b1;
    bus.new_cmd = 1'b0; bus.cmd_index_arg = '0; bus.resp_type = '0;
    bus.REQ_in = 1'b0; bus.ACK_in = 1'b0;
    repeat (3) @(negedge CLK_SD_card);
    chk("rst_inactive", bus.physical_inactive, 1);
    chk("rst_line", cmd_to_sd, 1);
    chk("rst_oe", cmd_to_sd_oe, 0);
    chk("rst_handshake", {bus.ACK_out, bus.REQ_out}, 0);
    chk("rst_errs", {bus.timeout_error, bus.crc_error}, 0);
    chk("rst_resp", bus.cmd_response, 0);
    reset = 1'b0;

    chk("model_pin_cmd2", cmd_frame(6'd2, 32'h0), 48'h42_0000_0000_4D);
    chk("model_pin_r7_crc", crc_div({80'b0, 40'h08_0000_01AA}, 40), 7'h09);

    // CMD0, no response
    run_cmd(6'd0, 32'h0, 2'b00, 48'h40_0000_0000_95, '0, 0, -1, '0, 1'b0, 1'b0, 0, 1'b0);
    // CMD17, valid R1-style reply
    run_cmd(6'd17, 32'h0, 2'b01, 48'h51_0000_0000_55, {88'b0, r7_good}, 48, 2,
            {90'b0, 38'h08_0000_01AA}, 1'b0, 1'b0, -1, 1'b0);
    // Same reply, corrupted CRC
    run_cmd(6'd17, 32'h0, 2'b01, 48'h51_0000_0000_55, {88'b0, r7_bad}, 48, 5,
            {90'b0, 38'h08_0000_01AA}, CRC_ON, 1'b0, -1, 1'b0);
    // CMD8, silent card -> timeout after exactly 64 cycles; stray controls during SEND
    run_cmd(6'd8, 32'h1AA, 2'b01, 48'h48_0000_01AA_87, '0, 0, -1, '0, 1'b0, 1'b1, 64, 1'b1);
    // Start bit on the final wait cycle wins over timeout
    run_cmd(6'd17, 32'h0, 2'b01, cmd_frame(6'd17, 32'h0), {88'b0, r7_good}, 48, 63,
            {90'b0, r7_good[45:8]}, short_crc_bad(r7_good, 2'b01), 1'b0, -1, 1'b0);
    // CMD2, long CID response, good then corrupted
    run_cmd(6'd2, 32'h0, 2'b10, cmd_frame(6'd2, 32'h0), long_good, 136, 3,
            long_good[127:0], long_crc_bad(long_good), 1'b0, -1, 1'b0);
    run_cmd(6'd2, 32'h0, 2'b10, cmd_frame(6'd2, 32'h0), long_bad, 136, 0,
            long_bad[127:0], CRC_ON, 1'b0, -1, 1'b0);
    // ACMD41 style R3: CRC never flagged
    run_cmd(6'd41, 32'h40FF_8000, 2'b11, cmd_frame(6'd41, 32'h40FF_8000), {88'b0, r3}, 48, 1,
            {90'b0, r3[45:8]}, short_crc_bad(r3, 2'b11), 1'b0, -1, 1'b0);

    // Reset while bit 20 of CMD17 is on the line
    chk_tx = 1'b0;
    @(negedge CLK_SD_card);
    bus.cmd_index_arg = {6'd17, 32'h0}; bus.resp_type = 2'b01; bus.new_cmd = 1'b1;
    @(negedge CLK_SD_card);
    bus.new_cmd = 1'b0; bus.REQ_in = 1'b1;
    n = 0;
    do begin @(negedge CLK_SD_card); n++; end while (bus.ACK_out !== 1'b1 && n < 20);
    chk("abort_ack", bus.ACK_out, 1);
    bus.REQ_in = 1'b0;
    repeat (27) @(negedge CLK_SD_card);
    chk("abort_bit20", cmd_to_sd, f17[20]);
    chk("abort_oe_before", cmd_to_sd_oe, 1);
    reset = 1'b1;
    @(negedge CLK_SD_card);
    chk("abort_oe_after", cmd_to_sd_oe, 0);
    chk("abort_inactive", bus.physical_inactive, 1);
    chk("abort_line", cmd_to_sd, 1);
    reset = 1'b0;
    chk_tx = 1'b1;
    run_cmd(6'd0, 32'h0, 2'b00, cmd_frame(6'd0, 32'h0), '0, 0, -1, '0, 1'b0, 1'b0, 0, 1'b0);

    repeat (5) @(negedge CLK_SD_card);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
